timer_event_ctrl: RTL
=====================

# timer_event_ctrl

Control stage directly downstream of the programmable timer counter. Drives the counter's `enable` and consumes its `done` terminal-count strobe as a tick. Counts a programmed number of ticks per expiry in one-shot or periodic mode and raises a sticky interrupt with acknowledge handshake. Counts expiries lost while the interrupt is still pending.

## Interface
- `CW`, 16: width of the tick-count (events per expiry) register.
- `MW`, 8: width of the missed-expiry counter.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request: load configuration and run.
- `stop`  in  1  single-cycle request: abort and return to idle.
- `periodic`  in  1  mode (1 = auto-reload, 0 = one-shot); sampled on accepted `start`.
- `event_count`  in  CW  ticks per expiry; sampled on accepted `start`; 0 treated as 1.
- `tick`  in  1  counter `done` output.
- `irq_ack`  in  1  clears the pending interrupt.
- `timer_en`  out  1  drives the counter `enable`.
- `busy`  out  1  high while in RUN.
- `irq`  out  1  sticky interrupt pending.
- `expired`  out  1  one-cycle pulse per expiry.
- `remaining`  out  CW  ticks left in the current period.
- `missed`  out  MW  expiries that occurred while `irq` was already pending; saturating.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `timer_en` = 0, `busy` = 0.
  - `start` → load `remaining` = max(`event_count`, 1), latch `periodic`, clear `missed`, go to RUN.
- RUN:
  - `timer_en` = 1, `busy` = 1.
  - A qualified tick is `tick & timer_en`; `tick` is ignored whenever `timer_en` is 0, because a paused counter can hold `done` high.
  - Qualified tick with `remaining` > 1 → `remaining` decrements by 1.
  - Qualified tick with `remaining` == 1 → expiry.
    - Periodic: reload the latched count and stay in RUN.
    - One-shot: `remaining` = 0 and go to IDLE.
- Expiry effects:
  - `expired` pulses for one cycle and `irq` is set.
  - If `irq` was already 1 and `irq_ack` is not asserted that cycle, `missed` increments, saturating at 2^MW−1.
- Stop and restart:
  - `stop` in RUN → IDLE; `remaining` holds its value; no expiry is generated.
  - `start` in RUN → restart: reload, re-latch mode, clear `missed`, stay in RUN.
- Simultaneous events:
  - `stop` and `start` together: `stop` wins.
  - `stop` with a qualified tick that would expire: `stop` wins, no expiry.
  - `start` with a qualified tick: `start` wins, tick discarded.
  - Expiry with `irq_ack`: set wins, `irq` stays 1, `missed` does not increment.
  - `irq_ack` with no expiry clears `irq`; `irq_ack` while `irq` is 0 has no effect.
- `irq` and `missed` persist across IDLE. `missed` is cleared only by an accepted `start` or by reset.
- The counter phase is not cleared by this block. The first period after a restart may be short by up to one counter period; this is by design.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `timer_en` 0, `busy` 0, `irq` 0, `expired` 0, `remaining` 0, `missed` 0.
- Reset mid-operation returns all outputs to these values immediately, independent of `clk`.
- `start` sampled at edge k → `timer_en`, `busy` and `remaining` update at k+1.
- Qualified tick at edge k with `remaining` == 1 → `expired` = 1 and `irq` = 1 at k+1. One-shot mode also gives `busy` = 0 and `timer_en` = 0 at k+1.
- `irq_ack` at edge k → `irq` = 0 at k+1.
- `stop` at edge k → `timer_en` = 0 at k+1.
- Tick-to-interrupt latency is 1 cycle.
- Back-to-back ticks on consecutive cycles must be handled, including periodic count 1 producing `expired` every tick.

## Structure
- Shared package `timer_pkg`:
  - state enum typedef `timer_state_t` {IDLE, RUN};
  - default-width constants `TIMER_CW` = 16 and `TIMER_MW` = 8.
- One natural sub-module: `sat_counter` (parameterised width; clear, increment, saturate), used for `missed`.
- FSM, reload register and `remaining` decrement stay in the top module.

## Test plan
- Reset, then one-shot with `event_count`=3 and one tick every 4 cycles → `remaining` goes 3,2,1. On the 3rd tick: `expired` pulses, `irq`=1, `busy`=0 one cycle later, `timer_en` drops.
- Periodic with `event_count`=1 and `tick` held high for 5 cycles → `expired` high for 5 consecutive cycles. With no ack: `irq`=1, `missed`=4.
- `event_count`=0 in one-shot → behaves as 1; expiry on the first qualified tick.
- `stop` coincident with the expiring tick (`remaining`=1) → no `expired`, `irq` stays 0, state IDLE, `remaining`=1.
- Periodic with `event_count`=2, pending `irq`, `irq_ack` on the same cycle as the next expiry → `irq` stays 1, `missed` unchanged. Next lone `irq_ack` → `irq`=0.
- Assert `reset_n`=0 mid-RUN with `irq`=1 and `missed`=255 (MW=8, saturated after 300 expiries) → all outputs 0 with no clock edge. `tick` while IDLE and after reset → no change.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer event controller.
package timer_pkg;

  localparam int TIMER_CW = 16;
  localparam int TIMER_MW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, clear on request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/timer_event_ctrl.sv
// Timer event controller: enables the downstream counter, counts its done
// strobes as ticks, and signals expiries through a sticky interrupt.
//
// Handshakes: start and stop are single-cycle requests, always accepted on the
// edge they are sampled (stop wins over start). irq is a level that stays high
// until irq_ack is seen on an edge with no simultaneous expiry; an expiry on
// the same edge as irq_ack keeps irq set.
module timer_event_ctrl
  import timer_pkg::*;
#(
  parameter int CW = TIMER_CW,
  parameter int MW = TIMER_MW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [CW-1:0] event_count,
  input  logic          tick,
  input  logic          irq_ack,
  output logic          timer_en,
  output logic          busy,
  output logic          irq,
  output logic          expired,
  output logic [CW-1:0] remaining,
  output logic [MW-1:0] missed,
  output logic          state_dbg
);

  timer_state_t  state, state_next;
  logic [CW-1:0] remaining_next;
  logic [CW-1:0] reload, reload_next;
  logic          periodic_q, periodic_next;
  logic [CW-1:0] load_value;
  logic          qtick;
  logic          start_acc;
  logic          expire;
  logic          miss_inc;

  // Both outputs are decoded straight from the state register.
  assign timer_en  = (state == RUN);
  assign busy      = (state == RUN);
  assign state_dbg = state;

  // A paused counter may hold done high, so ticks only count while enabled.
  assign qtick = tick & timer_en;

  // A programmed count of zero behaves as a count of one.
  assign load_value = (event_count == '0) ? CW'(1) : event_count;

  // Next-state, reload and remaining-count decisions.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    reload_next    = reload;
    periodic_next  = periodic_q;
    start_acc      = 1'b0;
    expire         = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          start_acc      = 1'b1;
          remaining_next = load_value;
          reload_next    = load_value;
          periodic_next  = periodic;
          state_next     = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort keeps remaining as-is and suppresses any expiry.
          state_next = IDLE;
        end else if (start) begin
          // Restart discards any coincident tick.
          start_acc      = 1'b1;
          remaining_next = load_value;
          reload_next    = load_value;
          periodic_next  = periodic;
        end else if (qtick) begin
          if (remaining > CW'(1)) begin
            remaining_next = remaining - CW'(1);
          end else begin
            expire = 1'b1;
            if (periodic_q) begin
              remaining_next = reload;
            end else begin
              remaining_next = '0;
              state_next     = IDLE;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, counting registers and the expiry pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      remaining  <= '0;
      reload     <= '0;
      periodic_q <= 1'b0;
      expired    <= 1'b0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      reload     <= reload_next;
      periodic_q <= periodic_next;
      expired    <= expire;
    end
  end

  // Sticky interrupt: a new expiry beats a coincident acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (expire) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end

  // An expiry is lost only if the previous one is still pending and unacknowledged.
  assign miss_inc = expire & irq & ~irq_ack;

  sat_counter #(
    .W(MW)
  ) u_missed (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (start_acc),
    .inc    (miss_inc),
    .count  (missed)
  );

endmodule
